btn_count3: RTL and testbench

Debounced push-button up/down counter producing the 3-bit digit value that drives the 7-segment decoder input `I`. It sits directly upstream of the decoder. Two raw board buttons are synchronised and debounced, then converted into single-cycle step events with hold-to-repeat. A wrapping 3-bit count 0..7 is presented on `Q`.

---
 rtl/btn_count3.sv | 178 +++++++++++++++++
 tb/tb_btn_count3.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_count3.sv
// btn_count3 - debounced push-button up/down counter feeding a 7-segment
// decoder input.
//
// Each raw button is synchronised (2 flops), debounced, edge-detected and
// fed to a hold-to-repeat FSM that emits single-cycle step requests. Up and
// down steps are resolved into a wrapping 3-bit count.
//
// Ports:
//   CLK    in   1  system clock, rising edge
//   RST_N  in   1  asynchronous active-low reset
//   BtnUp  in   1  raw up button (async, bouncing, active-high)
//   BtnDn  in   1  raw down button (async, bouncing, active-high)
//   Clr    in   1  synchronous clear of the count, active-high
//   Q      out  3  current count 0..7
//   Step   out  1  one-cycle pulse in the cycle after Q changed by a button
module btn_count3 #(
  parameter int DEBOUNCE      = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BtnUp,
  input  logic       BtnDn,
  input  logic       Clr,
  output logic [2:0] Q,
  output logic       Step
);

  localparam int DW   = $clog2(DEBOUNCE);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REPEAT
  } rep_state_e;

  // Index 0 = up, index 1 = down.
  logic [1:0] btn_raw;
  logic [1:0] step_w;

  assign btn_raw = {BtnDn, BtnUp};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]    sync_q;
      logic          acc_q;
      logic          acc_d;
      logic          acc_d1_q;
      logic [DW-1:0] db_cnt_q;
      logic [DW-1:0] db_cnt_d;
      logic          press_w;
      logic          release_w;
      rep_state_e    state_q;
      rep_state_e    state_d;
      logic [TW-1:0] tmr_q;
      logic [TW-1:0] tmr_d;
      logic          step_c;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          sync_q   <= '0;
          acc_q    <= 1'b0;
          acc_d1_q <= 1'b0;
          db_cnt_q <= '0;
          state_q  <= ST_IDLE;
          tmr_q    <= '0;
        end else begin
          sync_q   <= {sync_q[0], btn_raw[gi]};
          acc_q    <= acc_d;
          acc_d1_q <= acc_q;
          db_cnt_q <= db_cnt_d;
          state_q  <= state_d;
          tmr_q    <= tmr_d;
        end
      end

      // The counter only runs while the synchronised level disagrees with the
      // accepted level; any return to agreement (a bounce) restarts it.
      always_comb begin
        acc_d    = acc_q;
        db_cnt_d = '0;
        if (sync_q[1] != acc_q) begin
          if (db_cnt_q == DB_LAST) begin
            acc_d = sync_q[1];
          end else begin
            db_cnt_d = db_cnt_q + DW'(1);
          end
        end
      end

      assign press_w   = acc_q & ~acc_d1_q;
      assign release_w = ~acc_q & acc_d1_q;

      // Release takes priority over a repeat step due in the same cycle.
      always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        step_c  = 1'b0;
        case (state_q)
          ST_IDLE: begin
            tmr_d = '0;
            if (press_w) begin
              state_d = ST_WAIT;
              step_c  = 1'b1;
            end
          end
          ST_WAIT: begin
            if (release_w) begin
              state_d = ST_IDLE;
              tmr_d   = '0;
            end else if (tmr_q == RD_LAST) begin
              state_d = ST_REPEAT;
              tmr_d   = '0;
              step_c  = 1'b1;
            end else begin
              tmr_d = tmr_q + TW'(1);
            end
          end
          ST_REPEAT: begin
            if (release_w) begin
              state_d = ST_IDLE;
              tmr_d   = '0;
            end else if (tmr_q == RP_LAST) begin
              tmr_d  = '0;
              step_c = 1'b1;
            end else begin
              tmr_d = tmr_q + TW'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
          end
        endcase
      end

      assign step_w[gi] = step_c;
    end
  endgenerate

  logic [2:0] count_q;
  logic [2:0] count_d;
  logic       step_q;
  logic       step_d;

  // Coincident up and down steps cancel; Clr overrides everything.
  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    if (Clr) begin
      count_d = 3'd0;
    end else if (step_w[0] ^ step_w[1]) begin
      step_d  = 1'b1;
      count_d = step_w[0] ? count_q + 3'd1 : count_q - 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= 3'd0;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  assign Q    = count_q;
  assign Step = step_q;

endmodule

// File: tb/tb_btn_count3.sv
// Testbench for btn_count3 with DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Stimulus pushes the expected count (and spacing from the previous step)
// into a queue; a monitor pops and compares on every Step pulse.
module tb_btn_count3;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b1;
  logic       BtnUp = 1'b0;
  logic       BtnDn = 1'b0;
  logic       Clr   = 1'b0;
  logic [2:0] Q;
  logic       Step;

  always #5 CLK = ~CLK;

  btn_count3 #(
    .DEBOUNCE      (4),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (8)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .BtnUp (BtnUp),
    .BtnDn (BtnDn),
    .Clr   (Clr),
    .Q     (Q),
    .Step  (Step)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_step_cyc = 0;

  typedef struct {
    logic [2:0] q;
    int         gap;   // expected cycles since previous step, -1 = don't care
  } exp_t;

  exp_t exp_q[$];

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic expect_step(input int q, input int gap);
    exp_t e;
    logic [31:0] qv;
    qv    = q;
    e.q   = qv[2:0];
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: every Step pulse must match the next queued expectation.
  always @(negedge CLK) begin
    if (RST_N && Step === 1'b1) begin
      exp_t e;
      $display("step seen: Q=%0d at cycle %0d", Q, cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_step: Step=1 with Q=%0d, expected no step", Q);
      end else begin
        e = exp_q.pop_front();
        check("step_q", 32'(Q), 32'(e.q));
        if (e.gap >= 0) check("step_gap", cyc - last_step_cyc, e.gap);
      end
      last_step_cyc = cyc;
    end
  end

  task automatic press(input logic up, input logic dn, input int hold);
    @(negedge CLK);
    BtnUp = up;
    BtnDn = dn;
    repeat (hold) @(negedge CLK);
    BtnUp = 1'b0;
    BtnDn = 1'b0;
    repeat (14) @(negedge CLK);
  endtask

  task automatic do_clr();
    @(negedge CLK);
    Clr = 1'b1;
    @(negedge CLK);
    Clr = 1'b0;
    check("clr_q", 32'(Q), 0);
    check("clr_step", 32'(Step), 0);
  endtask

  initial begin
    // Reset and idle
    #2 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_q", 32'(Q), 0);
    check("reset_step", 32'(Step), 0);
    RST_N = 1'b1;
    repeat (50) @(negedge CLK);
    check("idle_q", 32'(Q), 0);
    $display("txn: reset + idle done, Q=%0d", Q);

    // Bounce every 2 cycles, then a short clean hold: one increment
    expect_step(1, -1);
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      BtnUp = (i % 2 == 0);
      @(negedge CLK);
    end
    repeat (5) @(negedge CLK);
    BtnUp = 1'b0;
    repeat (20) @(negedge CLK);
    check("bounce_q", 32'(Q), 1);
    $display("txn: bounce then hold, Q=%0d", Q);

    // Three down presses: 1 -> 0 -> 7 -> 6 (includes the 0 -> 7 wrap)
    expect_step(0, -1);
    press(1'b0, 1'b1, 6);
    check("dn_1_to_0", 32'(Q), 0);
    expect_step(7, -1);
    press(1'b0, 1'b1, 6);
    check("dn_wrap_0_to_7", 32'(Q), 7);
    expect_step(6, -1);
    press(1'b0, 1'b1, 6);
    check("dn_7_to_6", 32'(Q), 6);
    $display("txn: three down presses, Q=%0d", Q);

    // Hold up 60 cycles from 6: 7,0,1,2,3,4 at 0,20,28,36,44,52
    expect_step(7, -1);
    expect_step(0, 20);
    expect_step(1, 8);
    expect_step(2, 8);
    expect_step(3, 8);
    expect_step(4, 8);
    @(negedge CLK);
    BtnUp = 1'b1;
    repeat (60) @(negedge CLK);
    BtnUp = 1'b0;
    repeat (20) @(negedge CLK);
    check("hold_repeat_q", 32'(Q), 4);
    $display("txn: hold-repeat up, Q=%0d", Q);

    // Clear, then one down press from 0 wraps to 7
    do_clr();
    expect_step(7, -1);
    press(1'b0, 1'b1, 6);
    check("clr_then_dn_q", 32'(Q), 7);
    $display("txn: clear + down, Q=%0d", Q);

    // Both buttons together: coincident steps cancel
    press(1'b1, 1'b1, 10);
    check("both_q", 32'(Q), 7);
    $display("txn: both buttons, Q=%0d", Q);

    // Reach 3, then Clr in the same cycle as an up-step
    do_clr();
    expect_step(1, -1);
    press(1'b1, 1'b0, 6);
    expect_step(2, -1);
    press(1'b1, 1'b0, 6);
    expect_step(3, -1);
    press(1'b1, 1'b0, 6);
    check("up_to_3_q", 32'(Q), 3);
    @(negedge CLK);
    BtnUp = 1'b1;
    repeat (6) @(negedge CLK);
    Clr = 1'b1;
    @(negedge CLK);
    Clr = 1'b0;
    check("clr_vs_step_q", 32'(Q), 0);
    check("clr_vs_step_step", 32'(Step), 0);
    repeat (2) @(negedge CLK);
    BtnUp = 1'b0;
    repeat (20) @(negedge CLK);
    check("clr_vs_step_after_q", 32'(Q), 0);
    $display("txn: clear vs up-step, Q=%0d", Q);

    // Asynchronous reset mid-repeat at Q=5
    expect_step(1, -1);
    expect_step(2, 20);
    expect_step(3, 8);
    expect_step(4, 8);
    expect_step(5, 8);
    @(negedge CLK);
    BtnUp = 1'b1;
    repeat (53) @(negedge CLK);
    check("pre_reset_q", 32'(Q), 5);
    #2 RST_N = 1'b0;
    #1;
    check("async_reset_q", 32'(Q), 0);
    check("async_reset_step", 32'(Step), 0);
    BtnUp = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (30) @(negedge CLK);
    check("post_reset_q", 32'(Q), 0);
    $display("txn: reset mid-repeat, Q=%0d", Q);

    // Fresh press after reset counts normally
    expect_step(1, -1);
    press(1'b1, 1'b0, 6);
    check("fresh_press_q", 32'(Q), 1);
    $display("txn: fresh press, Q=%0d", Q);

    repeat (5) @(negedge CLK);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
